// File: rtl/lab1_imul_int_div_base.sv
// Iterative restoring divider (one quotient bit per cycle) with a val/rdy request/response stream.
// Handles signed and unsigned division with RISC-V DIV/DIVU/REM/REMU result semantics.

module lab1_imul_int_div_base #(
  parameter int NBITS = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               istream_val,
  output logic               istream_rdy,
  input  logic [2*NBITS:0]   istream_msg,
  output logic               ostream_val,
  input  logic               ostream_rdy,
  output logic [2*NBITS-1:0] ostream_msg
);

  localparam int CW = (NBITS > 1) ? $clog2(NBITS) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state;
  logic             is_signed_r;
  logic             dividend_neg;
  logic             divisor_neg;
  logic             div_by_zero;
  logic [NBITS-1:0] dividend_raw;
  logic [NBITS-1:0] divisor_r;
  logic [NBITS-1:0] rem_r;
  logic [NBITS-1:0] quo_r;
  logic [NBITS-1:0] result_rem;
  logic [NBITS-1:0] result_quo;
  logic [CW-1:0]    counter;

  logic             in_signed;
  logic [NBITS-1:0] in_dividend;
  logic [NBITS-1:0] in_divisor;
  logic             in_dividend_neg;
  logic             in_divisor_neg;
  logic [NBITS-1:0] in_dividend_mag;
  logic [NBITS-1:0] in_divisor_mag;

  logic [NBITS:0]   rem_shifted;
  logic [NBITS:0]   trial;
  logic             trial_ok;
  logic [NBITS-1:0] rem_next;
  logic [NBITS-1:0] quo_next;
  logic [NBITS-1:0] quo_fixed;
  logic [NBITS-1:0] rem_fixed;

  assign istream_rdy = (state == IDLE);
  assign ostream_val = (state == DONE);
  assign ostream_msg = {result_rem, result_quo};

  // Operand decode: magnitudes are only taken when the request is signed.
  always_comb begin
    in_signed       = istream_msg[2*NBITS];
    in_dividend     = istream_msg[2*NBITS-1:NBITS];
    in_divisor      = istream_msg[NBITS-1:0];
    in_dividend_neg = in_signed & in_dividend[NBITS-1];
    in_divisor_neg  = in_signed & in_divisor[NBITS-1];
    in_dividend_mag = in_dividend_neg ? (~in_dividend + 1'b1) : in_dividend;
    in_divisor_mag  = in_divisor_neg  ? (~in_divisor  + 1'b1) : in_divisor;
  end

  // Since rem < divisor is invariant, rem_shifted < 2*divisor, so the borrow
  // out of the N+1-bit subtraction is an exact sign of the trial remainder.
  always_comb begin
    rem_shifted = {rem_r, quo_r[NBITS-1]};
    trial       = rem_shifted - {1'b0, divisor_r};
    trial_ok    = ~trial[NBITS];
    rem_next    = trial_ok ? trial[NBITS-1:0] : rem_shifted[NBITS-1:0];
    quo_next    = {quo_r[NBITS-2:0], trial_ok};
  end

  // Sign fix-up on the final iteration; divide-by-zero overrides everything.
  always_comb begin
    quo_fixed = (is_signed_r && (dividend_neg ^ divisor_neg)) ? (~quo_next + 1'b1) : quo_next;
    rem_fixed = (is_signed_r && dividend_neg) ? (~rem_next + 1'b1) : rem_next;
    if (div_by_zero) begin
      quo_fixed = '1;
      rem_fixed = dividend_raw;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      is_signed_r  <= 1'b0;
      dividend_neg <= 1'b0;
      divisor_neg  <= 1'b0;
      div_by_zero  <= 1'b0;
      dividend_raw <= '0;
      divisor_r    <= '0;
      rem_r        <= '0;
      quo_r        <= '0;
      result_rem   <= '0;
      result_quo   <= '0;
      counter      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (istream_val) begin
            state        <= CALC;
            is_signed_r  <= in_signed;
            dividend_neg <= in_dividend_neg;
            divisor_neg  <= in_divisor_neg;
            div_by_zero  <= (in_divisor == '0);
            dividend_raw <= in_dividend;
            divisor_r    <= in_divisor_mag;
            rem_r        <= '0;
            quo_r        <= in_dividend_mag;
            counter      <= '0;
          end
        end
        CALC: begin
          rem_r   <= rem_next;
          quo_r   <= quo_next;
          counter <= counter + 1'b1;
          if (counter == CW'(NBITS - 1)) begin
            state      <= DONE;
            result_quo <= quo_fixed;
            result_rem <= rem_fixed;
          end
        end
        DONE: begin
          if (ostream_rdy) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lab1_imul_int_div_base.sv
// Directed and randomized-delay checks of the iterative divider against hand values and a golden model.

module tb_lab1_imul_int_div_base;

  localparam int NBITS = 32;

  logic               clk;
  logic               reset;
  logic               istream_val;
  logic               istream_rdy;
  logic [2*NBITS:0]   istream_msg;
  logic               ostream_val;
  logic               ostream_rdy;
  logic [2*NBITS-1:0] ostream_msg;

  int numChecks = 0;
  int numErrors = 0;

  lab1_imul_int_div_base #(.NBITS(NBITS)) dut (
    .clk         (clk),
    .reset       (reset),
    .istream_val (istream_val),
    .istream_rdy (istream_rdy),
    .istream_msg (istream_msg),
    .ostream_val (ostream_val),
    .ostream_rdy (ostream_rdy),
    .ostream_msg (ostream_msg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    numChecks++;
    if (observed !== expected) begin
      numErrors++;
      $display("[TB] FAIL %s: observed=0x%h expected=0x%h", tag, observed, expected);
    end
  endtask

  // RISC-V semantics computed with native arithmetic, independent of the shift-subtract datapath.
  function automatic logic [63:0] goldenDiv(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    int sa, sb, sq, sr;
    if (b == 32'd0) return {a, 32'hFFFFFFFF};
    if (sgn) begin
      if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'd0, 32'h80000000};
      sa = a;
      sb = b;
      sq = sa / sb;
      sr = sa % sb;
      return {sr[31:0], sq[31:0]};
    end
    return {a % b, a / b};
  endfunction

  // Sends one request after srcDelay idle cycles, then holds the sink off for sinkDelay cycles.
  task automatic applyStimulus(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                               input int srcDelay, input int sinkDelay,
                               output logic [63:0] resp, output int latency);
    int guard;
    logic [63:0] held;
    resp = '0;
    latency = 0;
    repeat (srcDelay) begin
      @(posedge clk);
      #1;
    end
    istream_val = 1'b1;
    istream_msg = {sgn, a, b};
    guard = 0;
    while (!istream_rdy && guard < 200) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (!istream_rdy) begin
      checkOutput("req_timeout", 64'(istream_rdy), 64'd1);
      istream_val = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    istream_val = 1'b0;
    istream_msg = '0;
    while (!ostream_val && latency < 200) begin
      checkOutput("rdy_in_calc", 64'(istream_rdy), 64'd0);
      @(posedge clk);
      #1;
      latency++;
    end
    if (!ostream_val) begin
      checkOutput("resp_timeout", 64'(ostream_val), 64'd1);
      return;
    end
    held = ostream_msg;
    for (int i = 0; i < sinkDelay; i++) begin
      @(posedge clk);
      #1;
      checkOutput("stall_val", 64'(ostream_val), 64'd1);
      checkOutput("stall_rdy", 64'(istream_rdy), 64'd0);
      checkOutput("stall_msg", ostream_msg, held);
    end
    resp = ostream_msg;
    ostream_rdy = 1'b1;
    @(posedge clk);
    #1;
    ostream_rdy = 1'b0;
    checkOutput("rdy_after_fire", 64'(istream_rdy), 64'd1);
    checkOutput("val_after_fire", 64'(ostream_val), 64'd0);
  endtask

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
    string       tag;
  } vec_t;

  initial begin
    vec_t vecs[$];
    logic [63:0] resp;
    int lat;
    logic sgn;
    logic [31:0] a, b;

    reset = 1'b1;
    istream_val = 1'b0;
    istream_msg = '0;
    ostream_rdy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput("reset_rdy", 64'(istream_rdy), 64'd1);
    checkOutput("reset_val", 64'(ostream_val), 64'd0);
    checkOutput("reset_msg", ostream_msg, 64'd0);

    applyStimulus(1'b0, 32'd100, 32'd7, 0, 0, resp, lat);
    checkOutput("unsigned_basic", resp, 64'h00000002_0000000E);
    checkOutput("latency_cycles", 64'(lat + 1), 64'd33);

    vecs.push_back('{1'b1, 32'hFFFFFFF9, 32'd2,        64'hFFFFFFFF_FFFFFFFD, "neg_by_pos"});
    vecs.push_back('{1'b1, 32'd7,        32'hFFFFFFFE, 64'h00000001_FFFFFFFD, "pos_by_neg"});
    vecs.push_back('{1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE, 64'hFFFFFFFF_00000003, "neg_by_neg"});
    vecs.push_back('{1'b0, 32'h12345678, 32'd0,        64'h12345678_FFFFFFFF, "divu_zero"});
    vecs.push_back('{1'b1, 32'hFFFFFFFB, 32'd0,        64'hFFFFFFFB_FFFFFFFF, "div_zero"});
    vecs.push_back('{1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, "signed_ovf"});
    vecs.push_back('{1'b0, 32'hFFFFFFFF, 32'd1,        64'h00000000_FFFFFFFF, "max_by_one"});
    vecs.push_back('{1'b0, 32'd3,        32'hFFFFFFFF, 64'h00000003_00000000, "small_by_max"});
    vecs.push_back('{1'b0, 32'hFFFFFFF9, 32'd2,        64'h00000001_7FFFFFFC, "unsigned_big"});
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].sgn, vecs[i].a, vecs[i].b, i % 3, i % 4, resp, lat);
      checkOutput(vecs[i].tag, resp, vecs[i].exp);
    end

    // Abort a transaction mid-CALC; result registers still hold the previous non-zero response.
    istream_val = 1'b1;
    istream_msg = {1'b0, 32'd100, 32'd7};
    @(posedge clk);
    #1;
    istream_val = 1'b0;
    istream_msg = '0;
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput("midreset_rdy", 64'(istream_rdy), 64'd1);
    checkOutput("midreset_val", 64'(ostream_val), 64'd0);
    checkOutput("midreset_msg", ostream_msg, 64'd0);
    applyStimulus(1'b0, 32'd9, 32'd4, 0, 0, resp, lat);
    checkOutput("post_reset", resp, 64'h00000001_00000002);

    for (int n = 0; n < 200; n++) begin
      sgn = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: a = $urandom;
        1: a = 32'($urandom_range(0, 1000));
        2: a = -32'($urandom_range(0, 1000));
        default: a = 32'h80000000;
      endcase
      case ($urandom_range(0, 4))
        0: b = $urandom;
        1: b = 32'($urandom_range(0, 20));
        2: b = -32'($urandom_range(1, 20));
        3: b = 32'hFFFFFFFF;
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      applyStimulus(sgn, a, b, $urandom_range(0, 5), $urandom_range(0, 5), resp, lat);
      checkOutput($sformatf("rand%0d", n), resp, goldenDiv(sgn, a, b));
    end

    $display("Simulation finished: %0d checks, %0d errors", numChecks, numErrors);
    $finish;
  end

endmodule
